// File: rtl/keypad_row_decoder_if.sv
// Keypad receive-side bundle: scanner column drive and raw rows in, decoded key events out.
interface keypad_row_decoder_if;
  logic [3:0] column;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_release;
  logic       key_held;

  modport master (
    output column, row,
    input  key_code, key_valid, key_release, key_held
  );

  modport slave (
    input  column, row,
    output key_code, key_valid, key_release, key_held
  );
endinterface

// File: rtl/keypad_row_decoder.sv
// Samples each settled column of the 4x4 keypad scan, assembles frames and debounces
// identical frames into press/release events with a held key code.
module keypad_row_decoder #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic               clkSlow,
  input  logic               rst_n,
  keypad_row_decoder_if.slave bus
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] DEB_TARGET  = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

  logic [3:0] row_meta, row_sync, col_prev;
  logic [7:0] settle_cnt;
  logic       col_ok;
  logic [1:0] col_idx;
  logic       sample_now;
  logic [2:0] row_lows;
  logic [1:0] row_pos;
  logic [1:0] exp_idx;
  logic [1:0] frame_lows, lows_acc;
  logic [3:0] frame_key, key_acc;
  logic       frame_done;

  state_t     state, state_next;
  logic [3:0] cand, cand_next, cnt, cnt_next;
  logic [3:0] key_code, key_code_next;
  logic       key_held, key_held_next;
  logic       key_valid, key_valid_next;
  logic       key_release, key_release_next;

  always_comb begin
    col_ok  = 1'b1;
    col_idx = 2'd0;
    case (bus.column)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_ok = 1'b0;
    endcase
  end

  assign sample_now = (bus.column == col_prev) && (settle_cnt == SETTLE_LAST);

  // A frame only needs the total number of low rows (saturated at 2) and the position of the first one.
  always_comb begin
    row_lows = 3'd0;
    row_pos  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row_sync[i]) begin
        row_lows = row_lows + 3'd1;
        row_pos  = 2'(i);
      end
    end
    lows_acc = (col_idx == 2'd0) ? 2'd0 : frame_lows;
    key_acc  = (col_idx == 2'd0) ? 4'd0 : frame_key;
    if (row_lows == 3'd1 && lows_acc == 2'd0) begin
      lows_acc = 2'd1;
      key_acc  = {row_pos, col_idx};
    end else if (row_lows != 3'd0) begin
      lows_acc = 2'd2;
    end
  end

  always_ff @(posedge clkSlow or negedge rst_n) begin
    if (!rst_n) begin
      row_meta   <= 4'b1111;
      row_sync   <= 4'b1111;
      col_prev   <= 4'b1111;
      settle_cnt <= 8'd0;
      exp_idx    <= 2'd0;
      frame_lows <= 2'd0;
      frame_key  <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      row_meta   <= bus.row;
      row_sync   <= row_meta;
      col_prev   <= bus.column;
      frame_done <= 1'b0;
      if (bus.column != col_prev)
        settle_cnt <= 8'd0;
      else if (settle_cnt != 8'hFF)
        settle_cnt <= settle_cnt + 8'd1;

      // An index-0 sample always restarts the frame; any other out-of-order sample drops it.
      if (sample_now) begin
        if (!col_ok) begin
          exp_idx <= 2'd0;
        end else if (col_idx == 2'd0 || col_idx == exp_idx) begin
          frame_lows <= lows_acc;
          frame_key  <= key_acc;
          if (col_idx == 2'd3) begin
            exp_idx    <= 2'd0;
            frame_done <= 1'b1;
          end else begin
            exp_idx <= col_idx + 2'd1;
          end
        end else begin
          exp_idx <= 2'd0;
        end
      end
    end
  end

  always_ff @(posedge clkSlow or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cand        <= 4'd0;
      cnt         <= 4'd0;
      key_code    <= 4'd0;
      key_held    <= 1'b0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_next;
      cand        <= cand_next;
      cnt         <= cnt_next;
      key_code    <= key_code_next;
      key_held    <= key_held_next;
      key_valid   <= key_valid_next;
      key_release <= key_release_next;
    end
  end

  always_comb begin
    state_next       = state;
    cand_next        = cand;
    cnt_next         = cnt;
    key_code_next    = key_code;
    key_held_next    = key_held;
    key_valid_next   = 1'b0;
    key_release_next = 1'b0;
    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_lows == 2'd1) begin
            state_next = DEB_PRESS;
            cand_next  = frame_key;
            cnt_next   = 4'd1;
          end
        end
        DEB_PRESS: begin
          if (frame_lows == 2'd1 && frame_key == cand) begin
            cnt_next = cnt + 4'd1;
            if ((cnt + 4'd1) == DEB_TARGET) begin
              state_next     = PRESSED;
              key_code_next  = cand;
              key_valid_next = 1'b1;
              key_held_next  = 1'b1;
            end
          end else if (frame_lows == 2'd1) begin
            cand_next = frame_key;
            cnt_next  = 4'd1;
          end else begin
            state_next = IDLE;
          end
        end
        PRESSED: begin
          if (frame_lows == 2'd0) begin
            state_next = DEB_REL;
            cnt_next   = 4'd1;
          end
        end
        DEB_REL: begin
          if (frame_lows == 2'd0) begin
            cnt_next = cnt + 4'd1;
            if ((cnt + 4'd1) == DEB_TARGET) begin
              state_next       = IDLE;
              key_held_next    = 1'b0;
              key_release_next = 1'b1;
            end
          end else begin
            state_next = PRESSED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.key_code    = key_code;
  assign bus.key_valid   = key_valid;
  assign bus.key_release = key_release;
  assign bus.key_held    = key_held;

endmodule
